// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among N_MASTERS with lock holding,
// SPLIT masking and default-master parking. All outputs are registered and
// advance only on HREADY edges; the split mask is tracked on every edge.
module ahb_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset_n,
  input  logic                 i_hready,
  input  logic [1:0]           i_hresp,
  input  logic [N_MASTERS-1:0] i_hbusreq,
  input  logic [N_MASTERS-1:0] i_hlock,
  input  logic [N_MASTERS-1:0] i_hsplit,
  output logic [N_MASTERS-1:0] o_hgrant,
  output logic [3:0]           o_hmaster,
  output logic [3:0]           o_hmaster_data,
  output logic                 o_hmastlock
);
  localparam int                   IW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [1:0]           RESP_RTY = 2'd2;
  localparam logic [1:0]           RESP_SPL = 2'd3;
  localparam logic [IW-1:0]        DEF_IDX  = IW'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] DEF_GNT  = N_MASTERS'(1) << DEFAULT_MASTER;

  logic [IW-1:0]        hmaster_q;
  logic [IW-1:0]        hmaster_data_q;
  logic [IW-1:0]        rr_ptr;
  logic [N_MASTERS-1:0] split_mask;

  logic [IW-1:0]        grant_idx;
  logic [N_MASTERS-1:0] elig;
  logic                 hold;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        scan_idx;
  logic                 scan_hit;
  logic [IW-1:0]        next_idx;
  logic [N_MASTERS-1:0] split_nxt;

  // Upper index bits are zero for narrow configurations.
  assign o_hmaster      = 4'(hmaster_q);
  assign o_hmaster_data = 4'(hmaster_data_q);

  // Encode the one-hot grant back into an index.
  always_comb begin
    grant_idx = '0;
    for (int n = 0; n < N_MASTERS; n++)
      if (o_hgrant[n]) grant_idx = IW'(n);
  end

  // Next-grant selection: lock/RETRY hold, else round-robin after rr_ptr,
  // else park on the default master. A masked holder never keeps the bus.
  always_comb begin
    elig     = i_hbusreq & ~split_mask;
    hold     = o_hmastlock && !split_mask[grant_idx] &&
               (i_hlock[hmaster_q] || (i_hresp == RESP_RTY));
    cand     = '0;
    scan_idx = DEF_IDX;
    scan_hit = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N_MASTERS);
      if (!scan_hit && elig[cand]) begin
        scan_idx = cand;
        scan_hit = 1'b1;
      end
    end
    if (hold)          next_idx = grant_idx;
    else if (scan_hit) next_idx = scan_idx;
    else               next_idx = DEF_IDX;
  end

  // Split mask: release by HSPLIT, then set for the data-phase owner (set wins).
  always_comb begin
    split_nxt = split_mask & ~i_hsplit;
    if (i_hready && (i_hresp == RESP_SPL))
      split_nxt[hmaster_data_q] = 1'b1;
  end

  // Split mask register, updated regardless of HREADY.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) split_mask <= '0;
    else             split_mask <= split_nxt;
  end

  // Grant/owner pipeline advances only when the bus is ready.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_hgrant       <= DEF_GNT;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      o_hmastlock    <= 1'b0;
      rr_ptr         <= DEF_IDX;
    end else if (i_hready) begin
      o_hgrant       <= N_MASTERS'(1) << next_idx;
      hmaster_q      <= grant_idx;
      hmaster_data_q <= hmaster_q;
      o_hmastlock    <= i_hlock[grant_idx];
      if (elig[next_idx]) rr_ptr <= next_idx;
    end
  end
endmodule
